// File: rtl/uart_regs_pkg.sv
// Shared definitions for the UART register file.
//   reg_idx_e    : register word index, i.e. byte address bits [7:2]
//   CTRL_*       : bit positions in CTRL
//   ST_*         : bit positions in STATUS
//   INT_*        : bit positions in INT_EN / INT_STAT (UART_REG_INT_EN builds)
//   reset values : CTRL_RESET, INT_EN_RESET
package uart_regs_pkg;

    typedef enum logic [5:0] {
        IDX_CTRL     = 6'h00,  // 0x00
        IDX_BAUD     = 6'h01,  // 0x04
        IDX_TX_DATA  = 6'h02,  // 0x08
        IDX_RX_DATA  = 6'h03,  // 0x0C
        IDX_STATUS   = 6'h04,  // 0x10
        IDX_INT_EN   = 6'h05,  // 0x14
        IDX_INT_STAT = 6'h06   // 0x18
    } reg_idx_e;

    localparam int unsigned CTRL_W          = 5;
    localparam int unsigned CTRL_TX_EN      = 0;
    localparam int unsigned CTRL_RX_EN      = 1;
    localparam int unsigned CTRL_PARITY_EN  = 2;
    localparam int unsigned CTRL_PARITY_ODD = 3;
    localparam int unsigned CTRL_STOP2      = 4;

    localparam int unsigned ST_TX_FULL   = 0;
    localparam int unsigned ST_TX_EMPTY  = 1;
    localparam int unsigned ST_RX_FULL   = 2;
    localparam int unsigned ST_RX_EMPTY  = 3;
    localparam int unsigned ST_TX_OVF    = 4;
    localparam int unsigned ST_RX_OVF    = 5;
    localparam int unsigned ST_FRAME_ERR = 6;

    localparam int unsigned INT_TX_EMPTY    = 0;
    localparam int unsigned INT_RX_NOTEMPTY = 1;
    localparam int unsigned INT_OVF_ANY     = 2;
    localparam int unsigned INT_FRAME_ERR   = 3;

    localparam logic [CTRL_W-1:0] CTRL_RESET   = '0;
    localparam logic [3:0]        INT_EN_RESET = '0;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   push, push_data : write one entry (accepted when not full, or full with pop)
//   pop           : remove head entry (ignored when empty)
//   head          : current head entry; 0 when empty
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_apb_regfile.sv
// UART register file behind the APB bridge reg_* strobe interface.
//   PCLK, PRESETn          : clock, asynchronous active-low reset
//   reg_wr_en/addr/data    : one-cycle register write strobe
//   reg_rd_en/addr, reg_rd_data : read strobe (side effects), combinational read data
//   tx_valid/tx_data/tx_ready   : byte stream to the TX core (TX FIFO head)
//   rx_valid/rx_data/rx_frame_err : bytes and error pulses from the RX core
//   ctrl_*, baud_div       : configuration outputs
//   irq                    : registered interrupt, present only with UART_REG_INT_EN
// Optional feature macro: UART_REG_INT_EN (INT_EN at 0x14, INT_STAT at 0x18, irq port).
module uart_apb_regfile
    import uart_regs_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd27
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        reg_wr_en,
    input  logic [31:0] reg_wr_addr,
    input  logic [31:0] reg_wr_data,
    input  logic        reg_rd_en,
    input  logic [31:0] reg_rd_addr,
    output logic [31:0] reg_rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_frame_err,
    output logic        ctrl_tx_en,
    output logic        ctrl_rx_en,
    output logic        ctrl_parity_en,
    output logic        ctrl_parity_odd,
    output logic        ctrl_stop2,
    output logic [15:0] baud_div
`ifdef UART_REG_INT_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [CTRL_W-1:0] ctrl_q;
    logic [15:0]       baud_q;
    logic              tx_ovf_q, rx_ovf_q, frame_err_q;

    logic [5:0] wr_idx, rd_idx;
    logic       wr_ctrl, wr_baud, wr_tx, wr_status, rd_rx;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic [2:0]    w1c_clr;
    logic [31:0]   status_word;

    assign wr_idx = reg_wr_addr[7:2];
    assign rd_idx = reg_rd_addr[7:2];

    always_comb begin
        wr_ctrl   = 1'b0;
        wr_baud   = 1'b0;
        wr_tx     = 1'b0;
        wr_status = 1'b0;
        if (reg_wr_en) begin
            case (wr_idx)
                IDX_CTRL:    wr_ctrl   = 1'b1;
                IDX_BAUD:    wr_baud   = 1'b1;
                IDX_TX_DATA: wr_tx     = 1'b1;
                IDX_STATUS:  wr_status = 1'b1;
                default:     ;
            endcase
        end
    end

    assign rd_rx   = reg_rd_en && (rd_idx == IDX_RX_DATA);
    assign tx_push = wr_tx;
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_push = rx_valid && ctrl_rx_en;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .push      (tx_push),
        .push_data (reg_wr_data[7:0]),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rd_rx),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign tx_valid = !tx_empty;
    assign w1c_clr  = wr_status ? reg_wr_data[6:4] : '0;

    // Sticky bits: a set in the same cycle as its W1C clear wins.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q      <= CTRL_RESET;
            baud_q      <= DEFAULT_BAUD_DIV;
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= reg_wr_data[CTRL_W-1:0];
            if (wr_baud) baud_q <= reg_wr_data[15:0];
            tx_ovf_q    <= (tx_ovf_q    && !w1c_clr[0]) || (tx_push && tx_full && !tx_pop);
            rx_ovf_q    <= (rx_ovf_q    && !w1c_clr[1]) || (rx_push && rx_full && !rd_rx);
            frame_err_q <= (frame_err_q && !w1c_clr[2]) || rx_frame_err;
        end
    end

    assign ctrl_tx_en      = ctrl_q[CTRL_TX_EN];
    assign ctrl_rx_en      = ctrl_q[CTRL_RX_EN];
    assign ctrl_parity_en  = ctrl_q[CTRL_PARITY_EN];
    assign ctrl_parity_odd = ctrl_q[CTRL_PARITY_ODD];
    assign ctrl_stop2      = ctrl_q[CTRL_STOP2];
    assign baud_div        = baud_q;

    always_comb begin
        status_word               = '0;
        status_word[ST_TX_FULL]   = tx_full;
        status_word[ST_TX_EMPTY]  = tx_empty;
        status_word[ST_RX_FULL]   = rx_full;
        status_word[ST_RX_EMPTY]  = rx_empty;
        status_word[ST_TX_OVF]    = tx_ovf_q;
        status_word[ST_RX_OVF]    = rx_ovf_q;
        status_word[ST_FRAME_ERR] = frame_err_q;
        status_word[15:8]         = 8'(rx_count);
    end

`ifdef UART_REG_INT_EN
    logic [3:0] int_en_q;
    logic [3:0] int_stat;
    logic       irq_q;

    always_comb begin
        int_stat                  = '0;
        int_stat[INT_TX_EMPTY]    = tx_empty;
        int_stat[INT_RX_NOTEMPTY] = !rx_empty;
        int_stat[INT_OVF_ANY]     = tx_ovf_q || rx_ovf_q;
        int_stat[INT_FRAME_ERR]   = frame_err_q;
        int_stat                  = int_stat & int_en_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            int_en_q <= INT_EN_RESET;
            irq_q    <= 1'b0;
        end else begin
            if (reg_wr_en && (wr_idx == IDX_INT_EN)) int_en_q <= reg_wr_data[3:0];
            irq_q <= |int_stat;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        reg_rd_data = '0;
        case (rd_idx)
            IDX_CTRL:     reg_rd_data[CTRL_W-1:0] = ctrl_q;
            IDX_BAUD:     reg_rd_data[15:0]       = baud_q;
            IDX_RX_DATA:  reg_rd_data[7:0]        = rx_head;
            IDX_STATUS:   reg_rd_data             = status_word;
`ifdef UART_REG_INT_EN
            IDX_INT_EN:   reg_rd_data[3:0]        = int_en_q;
            IDX_INT_STAT: reg_rd_data[3:0]        = int_stat;
`endif
            default:      reg_rd_data             = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, reg_wr_addr[31:8], reg_wr_addr[1:0], reg_rd_addr[31:8],
                           reg_rd_addr[1:0], reg_wr_data[31:16], tx_count};

endmodule
